anubis_host_link: RTL and testbench

ANUBIS_HOST_LINK -- requirements
Module: anubis_host_link

---
 rtl/anubis_link_pkg.sv | 11 +
 rtl/link_bit_tick.sv | 27 ++
 rtl/anubis_host_link.sv | 157 +++++++++++++++
 tb/tb_anubis_host_link.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/anubis_link_pkg.sv
// Shared constants and FSM encoding for the host-side link and the device-side serial blocks.
package anubis_link_pkg;
  localparam int TX_FRAME_BITS = 257;  // {mode, data[127:0], key[127:0]}
  localparam int RX_FRAME_BITS = 128;  // returned cipher/plain block
  localparam int BLK_W         = 128;
  localparam int BIT_CNT_W     = $clog2(TX_FRAME_BITS);

  typedef enum logic [3:0] {
    IDLE, REQ, SEND, REL, WAIT_RES, RECV, CLOSE, DONE, ERR
  } link_state_t;
endpackage

// File: rtl/link_bit_tick.sv
// Bit-period counter: boundary on the wrap cycle, mid strobe at CLK_DIV/2.
module link_bit_tick #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic boundary,
  output logic mid
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] MIDPT = CW'(CLK_DIV / 2);

  logic [CW-1:0] cnt;

  // free-running 0..CLK_DIV-1; restart realigns so the next cycle is the start of a period
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt <= '0;
    else if (restart || cnt == LAST) cnt <= '0;
    else                             cnt <= cnt + CW'(1);
  end

  // strobes are suppressed on the restart cycle so a stale period never leaks into a new phase
  assign boundary = !restart && (cnt == LAST);
  assign mid      = !restart && (cnt == MIDPT);
endmodule

// File: rtl/anubis_host_link.sv
// Host side of the Anubis serial link: sends {mode,data,key}, collects the 128-bit result.
module anubis_host_link
  import anubis_link_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic             mode,
  input  logic [BLK_W-1:0] data_in,
  input  logic [BLK_W-1:0] key_in,
  output logic             TxD,
  output logic             host_sync,
  output logic             host_ack,
  input  logic             RxD,
  input  logic             dev_sync,
  input  logic             dev_ack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [BLK_W-1:0] result
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

  link_state_t                state;
  logic [TX_FRAME_BITS-1:0]   tx_sr;
  logic [RX_FRAME_BITS-1:0]   rx_sr;
  logic [BIT_CNT_W-1:0]       bit_cnt;
  logic [TW-1:0]              tmo;
  logic [1:0]                 sync_q, ack_q, rxd_q;
  logic                       sync_s, ack_s, rxd_s;
  logic                       restart, boundary, mid;
  logic                       counting, advance, timeout;

  // two-flop synchronizers on every device-driven input
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      sync_q <= '0;
      ack_q  <= '0;
      rxd_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], dev_sync};
      ack_q  <= {ack_q[0], dev_ack};
      rxd_q  <= {rxd_q[0], RxD};
    end
  end

  assign sync_s = sync_q[1];
  assign ack_s  = ack_q[1];
  assign rxd_s  = rxd_q[1];

  // period realigns on accept (timeout base), on entering SEND and on entering RECV
  assign restart = (state == IDLE && start) || (state == REQ && ack_s) ||
                   (state == WAIT_RES && sync_s);

  link_bit_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (clk),
    .rst      (reset_b),
    .restart  (restart),
    .boundary (boundary),
    .mid      (mid)
  );

  // handshake states wait on the device; a state that is leaving this cycle never times out
  assign counting = (state == REQ) || (state == REL) || (state == WAIT_RES) || (state == CLOSE);
  assign advance  = (state == REQ && ack_s) || (state == REL && !ack_s) ||
                    (state == WAIT_RES && sync_s) || (state == CLOSE && !sync_s);
  assign timeout  = counting && !advance && boundary && (tmo == TMO_LAST);

  // transaction FSM with registered outputs
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state     <= IDLE;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      tmo       <= '0;
      TxD       <= 1'b0;
      host_sync <= 1'b0;
      host_ack  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      result    <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (counting && boundary && tmo != TMO_MAX) tmo <= tmo + TW'(1);
      if (timeout) begin
        state     <= ERR;
        error     <= 1'b1;
        host_sync <= 1'b0;
        host_ack  <= 1'b0;
        TxD       <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            tx_sr     <= {mode, data_in, key_in};
            busy      <= 1'b1;
            host_sync <= 1'b1;
            tmo       <= '0;
            state     <= REQ;
          end
          REQ: if (ack_s) begin
            TxD     <= tx_sr[TX_FRAME_BITS-1];
            bit_cnt <= '0;
            state   <= SEND;
          end
          SEND: if (boundary) begin
            tx_sr <= tx_sr << 1;
            if (bit_cnt == BIT_CNT_W'(TX_FRAME_BITS - 1)) begin
              TxD       <= 1'b0;
              host_sync <= 1'b0;
              tmo       <= '0;
              state     <= REL;
            end else begin
              TxD     <= tx_sr[TX_FRAME_BITS-2];
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
          REL: if (!ack_s) begin
            tmo   <= '0;
            state <= WAIT_RES;
          end
          WAIT_RES: if (sync_s) begin
            host_ack <= 1'b1;
            bit_cnt  <= '0;
            state    <= RECV;
          end
          RECV: if (mid) begin
            rx_sr   <= {rx_sr[RX_FRAME_BITS-2:0], rxd_s};
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == BIT_CNT_W'(RX_FRAME_BITS - 1)) begin
              host_ack <= 1'b0;
              tmo      <= '0;
              state    <= CLOSE;
            end
          end
          CLOSE: if (!sync_s) begin
            result <= rx_sr;
            done   <= 1'b1;
            state  <= DONE;
          end
          DONE, ERR: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_anubis_host_link.sv
// Directed bench with a device model and expected-frame/result scoreboard queues.
module tb_anubis_host_link;
  localparam int CLK_DIV = 4;
  localparam int TIMEOUT = 16;
  localparam int TXB     = 257;

  localparam logic [127:0] D_A = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] K_A = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] R_A = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

  logic         clk = 1'b0, reset_b = 1'b1;
  logic         start = 1'b0, mode = 1'b0;
  logic [127:0] data_in = '0, key_in = '0;
  logic         RxD = 1'b0, dev_sync = 1'b0, dev_ack = 1'b0;
  logic         TxD, host_sync, host_ack, busy, done, error;
  logic [127:0] result;

  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0;
  logic [256:0] exp_tx_q[$];
  logic [127:0] exp_res_q[$];

  always #5 clk = ~clk;

  anubis_host_link #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .mode(mode),
    .data_in(data_in), .key_in(key_in), .TxD(TxD), .host_sync(host_sync),
    .host_ack(host_ack), .RxD(RxD), .dev_sync(dev_sync), .dev_ack(dev_ack),
    .busy(busy), .done(done), .error(error), .result(result)
  );

  // pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (done === 1'b1)  done_cnt++;
    if (error === 1'b1) err_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // sel: 0 host_sync, 1 host_ack, 2 done
  task automatic wait_hs(input int sel, input logic val, input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (((sel == 0) ? host_sync : (sel == 1) ? host_ack : done) === val) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    if (!ok) begin
      checks++;
      assert (ok) else begin
        errors++;
        $error("FAIL %s observed=timeout expected=%b", tag, val);
      end
    end
  endtask

  task automatic do_start(input logic m, input logic [127:0] d, input logic [127:0] k,
                          input logic [127:0] r, input bit push);
    mode = m; data_in = d; key_in = k; start = 1'b1;
    if (push) begin
      exp_tx_q.push_back({m, d, k});
      exp_res_q.push_back(r);
    end
    tick(1);
    start = 1'b0; mode = ~m; data_in = ~d; key_in = ~k;
  endtask

  // full transaction driven by the device model; optional stray start and reset injection
  task automatic run_txn(input logic m, input logic [127:0] d, input logic [127:0] k,
                         input logic [127:0] r, input int inj, input int rst_bit);
    logic [256:0] got, exp_f;
    logic [127:0] exp_r;
    bit ok;
    int dc;
    got = '0;
    dc = done_cnt;
    do_start(m, d, k, r, 1'b1);
    wait_hs(0, 1'b1, "host_sync_rise", ok);
    if (!ok) return;
    dev_ack = 1'b1;
    tick(3);
    for (int b = 0; b < TXB; b++) begin
      tick(2);
      got = {got[255:0], TxD};
      if (b == inj) begin
        mode = ~m; data_in = ~d; key_in = ~k; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
      end else tick(2);
    end
    exp_f = exp_tx_q.pop_front();
    chk("tx_frame", got, exp_f);
    chk("tx_mode_bit", got[256], m);
    wait_hs(0, 1'b0, "host_sync_fall", ok);
    if (!ok) return;
    chk("txd_rel", TxD, 1'b0);
    dev_ack = 1'b0;
    tick(4);
    dev_sync = 1'b1;
    RxD = r[127];
    tick(7);
    chk("host_ack_rise", host_ack, 1'b1);
    for (int b = 1; b < 128; b++) begin
      RxD = r[127-b];
      if (b == rst_bit) begin
        reset_b = 1'b1;
        #1;
        chk("reset_mid_recv", {TxD, host_sync, host_ack, busy, done, error, result}, '0);
        exp_r = exp_res_q.pop_front();
        dev_sync = 1'b0; RxD = 1'b0;
        tick(3);
        chk("reset_no_pulse", done_cnt - dc, 0);
        reset_b = 1'b0;
        tick(1);
        return;
      end
      tick(4);
    end
    wait_hs(1, 1'b0, "host_ack_fall", ok);
    if (!ok) return;
    dev_sync = 1'b0;
    RxD = 1'b0;
    wait_hs(2, 1'b1, "done_pulse", ok);
    if (!ok) return;
    exp_r = exp_res_q.pop_front();
    chk("result", result, exp_r);
    tick(1);
    chk("busy_after_done", busy, 1'b0);
    chk("done_one_cycle", done, 1'b0);
    chk("done_count", done_cnt - dc, 1);
  endtask

  initial begin
    int n, ec;
    tick(3);
    chk("reset_state", {TxD, host_sync, host_ack, busy, done, error, result}, '0);
    reset_b = 1'b0;
    tick(2);

    // encrypt with a stray start during SEND
    run_txn(1'b1, D_A, K_A, R_A, 100, -1);

    // handshake timeout: device never acknowledges
    ec = err_cnt;
    do_start(1'b0, 128'h1, 128'h2, '0, 1'b0);
    chk("busy_after_start", busy, 1'b1);
    n = 0;
    while (error !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    chk("err_latency", n, CLK_DIV * TIMEOUT);
    chk("err_host_sync", host_sync, 1'b0);
    chk("err_host_ack", host_ack, 1'b0);
    chk("err_result_hold", result, R_A);
    tick(1);
    chk("busy_after_err", busy, 1'b0);
    chk("err_count", err_cnt - ec, 1);

    // reset mid-RECV, then a clean transaction
    run_txn(1'b0, 128'hDEADBEEF_00000000_CAFEF00D_12345678, K_A, 128'h5555_AAAA_0000_FFFF_1234_5678_9ABC_DEF0, -1, 50);
    run_txn(1'b1, 128'hFFFF0000FFFF0000FFFF0000FFFF0000, 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F,
            128'h80000000000000000000000000000001, -1, -1);

    // back-to-back decrypt then encrypt
    run_txn(1'b0, R_A, K_A, D_A, -1, -1);
    run_txn(1'b1, D_A, 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 128'h0123456789ABCDEFFEDCBA9876543210, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
